// File: rtl/subword_sequencer.sv
// Byte-serial AES SubWord controller: steps a shared 4:1 byte mux through the
// four bytes of word_q and collects the shared S-box results into out_word.
module subword_sequencer #(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic [31:0] word_q,
  output logic        sel_s1,
  output logic        sel_s2,
  input  logic [7:0]  sbox_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for in_valid; in_ready high
  // ISSUE | driving byte index k = 0..3 onto the mux selects
  // DRAIN | waiting for the last S-box result to emerge
  // DONE  | out_word valid; waiting for out_ready
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [1:0] DRAIN_LD = (SBOX_LAT > 0) ? 2'(SBOX_LAT - 1) : 2'd0;

  state_t     state, state_nxt;
  logic [1:0] k_q;
  logic [1:0] drain_cnt;
  logic       issue_v;
  logic       cap_v;
  logic [1:0] cap_idx;

  assign issue_v = (state == ISSUE);
  assign sel_s1  = k_q[1];
  assign sel_s2  = k_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (k_q == 2'd3) state_nxt = (SBOX_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == 2'd0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Select register doubles as the issue index; it wraps to 0 after the last issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       k_q <= 2'd0;
    else if (issue_v) k_q <= k_q + 2'd1;
    else              k_q <= 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drain_cnt <= 2'd0;
    else if (issue_v && (k_q == 2'd3))
      drain_cnt <= DRAIN_LD;
    else if ((state == DRAIN) && (drain_cnt != 2'd0))
      drain_cnt <= drain_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        word_q <= 32'd0;
    else if ((state == IDLE) && in_valid) word_q <= in_word;
  end

  // Issue tracking: each issue's index follows the S-box pipeline so the result
  // lands in the right byte lane when it emerges.
  if (SBOX_LAT == 0) begin : g_direct
    assign cap_v   = issue_v;
    assign cap_idx = k_q;
  end else begin : g_pipe
    logic [SBOX_LAT-1:0] pv;
    logic [1:0]          pidx [SBOX_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pv <= '0;
        for (int i = 0; i < SBOX_LAT; i++) pidx[i] <= 2'd0;
      end else begin
        pv[0]   <= issue_v;
        pidx[0] <= k_q;
        for (int i = 1; i < SBOX_LAT; i++) begin
          pv[i]   <= pv[i-1];
          pidx[i] <= pidx[i-1];
        end
      end
    end

    assign cap_v   = pv[SBOX_LAT-1];
    assign cap_idx = pidx[SBOX_LAT-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_word <= 32'd0;
    end else if (cap_v) begin
      case (cap_idx)
        2'd0:    out_word[7:0]   <= sbox_byte;
        2'd1:    out_word[15:8]  <= sbox_byte;
        2'd2:    out_word[23:16] <= sbox_byte;
        default: out_word[31:24] <= sbox_byte;
      endcase
    end
  end

endmodule

// File: tb/tb_subword_sequencer.sv
// Bench for subword_sequencer: three builds (SBOX_LAT 0, 1, 3) share one stimulus
// stream, each with its own modelled S-box pipeline, checked against a SubWord model.
module tb_subword_sequencer;
  localparam int NI = 3;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_word;
  logic        in_ready_a [NI];
  logic        sel_s1_a [NI];
  logic        sel_s2_a [NI];
  logic        out_valid_a [NI];
  logic        busy_a [NI];
  logic [31:0] word_q_a [NI];
  logic [31:0] out_word_a [NI];
  logic [7:0]  sbox_a [NI];
  int          lat_a [NI] = '{0, 1, 3};
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] subword(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = SBOX[w[8*i +: 8]];
    return r;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    logic [7:0] mux_b;
    always_comb begin
      mux_b = 8'h00;
      case ({sel_s1_a[g], sel_s2_a[g]})
        2'd0: mux_b = word_q_a[g][7:0];
        2'd1: mux_b = word_q_a[g][15:8];
        2'd2: mux_b = word_q_a[g][23:16];
        default: mux_b = word_q_a[g][31:24];
      endcase
    end
    if (L == 0) begin : g_comb
      assign sbox_a[g] = SBOX[mux_b];
    end else begin : g_reg
      logic [7:0] d [L];
      always @(posedge clk) begin
        d[0] <= SBOX[mux_b];
        for (int i = 1; i < L; i++) d[i] <= d[i-1];
      end
      assign sbox_a[g] = d[L-1];
    end
    subword_sequencer #(.SBOX_LAT(L)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a[g]),
      .in_word(in_word), .word_q(word_q_a[g]), .sel_s1(sel_s1_a[g]), .sel_s2(sel_s2_a[g]),
      .sbox_byte(sbox_a[g]), .out_valid(out_valid_a[g]), .out_ready(out_ready),
      .out_word(out_word_a[g]), .busy(busy_a[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every instance must sit at its reset values.
  task automatic check_reset_values(input string tag);
    for (int i = 0; i < NI; i++) begin
      n_checks++; if (in_ready_a[i] !== 1'b1) $display("FAIL %s in_ready lat%0d got %b exp 1", tag, lat_a[i], in_ready_a[i]); else n_pass++;
      n_checks++; if (busy_a[i] !== 1'b0) $display("FAIL %s busy lat%0d got %b exp 0", tag, lat_a[i], busy_a[i]); else n_pass++;
      n_checks++; if (out_valid_a[i] !== 1'b0) $display("FAIL %s out_valid lat%0d got %b exp 0", tag, lat_a[i], out_valid_a[i]); else n_pass++;
      n_checks++; if ({sel_s1_a[i], sel_s2_a[i]} !== 2'b00) $display("FAIL %s sel lat%0d got %b%b exp 00", tag, lat_a[i], sel_s1_a[i], sel_s2_a[i]); else n_pass++;
      n_checks++; if (word_q_a[i] !== 32'h0) $display("FAIL %s word_q lat%0d got %h exp 0", tag, lat_a[i], word_q_a[i]); else n_pass++;
      n_checks++; if (out_word_a[i] !== 32'h0) $display("FAIL %s out_word lat%0d got %h exp 0", tag, lat_a[i], out_word_a[i]); else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_word = 32'h0;
    #3;
    check_reset_values("reset_async");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_reset_values("reset_release");
  endtask

  // Accept one word with out_ready high and check the whole per-cycle timeline.
  task automatic run_word(input logic [31:0] w, input string tag);
    logic [31:0] exp_w;
    exp_w = subword(w);
    out_ready = 1'b1; in_valid = 1'b1; in_word = w;
    for (int i = 0; i < NI; i++) begin
      n_checks++; if (in_ready_a[i] !== 1'b1) $display("FAIL %s accept_ready lat%0d got %b exp 1", tag, lat_a[i], in_ready_a[i]); else n_pass++;
    end
    tick();
    in_valid = 1'b0; in_word = $urandom();
    for (int c = 1; c <= 9; c++) begin
      for (int i = 0; i < NI; i++) begin
        int L;
        logic [1:0] exp_sel;
        logic exp_v, exp_rdy;
        L = lat_a[i];
        exp_sel = (c <= 4) ? 2'(c - 1) : 2'b00;
        exp_v = (c == 5 + L);
        exp_rdy = (c >= 6 + L);
        n_checks++; if ({sel_s1_a[i], sel_s2_a[i]} !== exp_sel) $display("FAIL %s sel lat%0d c%0d got %b%b exp %b", tag, L, c, sel_s1_a[i], sel_s2_a[i], exp_sel); else n_pass++;
        n_checks++; if (out_valid_a[i] !== exp_v) $display("FAIL %s out_valid lat%0d c%0d got %b exp %b", tag, L, c, out_valid_a[i], exp_v); else n_pass++;
        n_checks++; if (in_ready_a[i] !== exp_rdy) $display("FAIL %s in_ready lat%0d c%0d got %b exp %b", tag, L, c, in_ready_a[i], exp_rdy); else n_pass++;
        n_checks++; if (busy_a[i] !== !exp_rdy) $display("FAIL %s busy lat%0d c%0d got %b exp %b", tag, L, c, busy_a[i], !exp_rdy); else n_pass++;
        n_checks++; if (word_q_a[i] !== w) $display("FAIL %s word_q lat%0d c%0d got %h exp %h", tag, L, c, word_q_a[i], w); else n_pass++;
        if (exp_v) begin
          n_checks++; if (out_word_a[i] !== exp_w) $display("FAIL %s out_word lat%0d got %h exp %h", tag, L, out_word_a[i], exp_w); else n_pass++;
        end
      end
      tick();
    end
  endtask

  task automatic test_basic();
    run_word(32'h01020304, "basic");
  endtask

  task automatic test_no_residue();
    run_word(32'h00000000, "zero");
    run_word(32'hcf53cf53, "residue");
  endtask

  task automatic test_random_words();
    for (int n = 0; n < 6; n++) run_word($urandom(), "random");
  endtask

  task automatic test_hold_output();
    logic [31:0] w, exp_w;
    w = $urandom(); exp_w = subword(w);
    out_ready = 1'b0; in_valid = 1'b1; in_word = w;
    tick();
    for (int c = 1; c <= 18; c++) begin
      in_valid = (c == 18) ? 1'b0 : 1'($urandom_range(0, 1));
      in_word = $urandom();
      out_ready = (c == 18);
      for (int i = 0; i < NI; i++) begin
        int L;
        logic exp_v;
        L = lat_a[i];
        exp_v = (c >= 5 + L);
        n_checks++; if (out_valid_a[i] !== exp_v) $display("FAIL hold out_valid lat%0d c%0d got %b exp %b", L, c, out_valid_a[i], exp_v); else n_pass++;
        n_checks++; if (in_ready_a[i] !== 1'b0) $display("FAIL hold in_ready lat%0d c%0d got %b exp 0", L, c, in_ready_a[i]); else n_pass++;
        n_checks++; if (word_q_a[i] !== w) $display("FAIL hold word_q lat%0d c%0d got %h exp %h", L, c, word_q_a[i], w); else n_pass++;
        if (exp_v) begin
          n_checks++; if (out_word_a[i] !== exp_w) $display("FAIL hold out_word lat%0d c%0d got %h exp %h", L, c, out_word_a[i], exp_w); else n_pass++;
        end
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      n_checks++; if (in_ready_a[i] !== 1'b1) $display("FAIL release in_ready lat%0d got %b exp 1", lat_a[i], in_ready_a[i]); else n_pass++;
      n_checks++; if (out_valid_a[i] !== 1'b0) $display("FAIL release out_valid lat%0d got %b exp 0", lat_a[i], out_valid_a[i]); else n_pass++;
      n_checks++; if (busy_a[i] !== 1'b0) $display("FAIL release busy lat%0d got %b exp 0", lat_a[i], busy_a[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1; in_valid = 1'b1; in_word = $urandom() | 32'h01010101;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_reset_values("abort_async");
    tick(); tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NI; i++) begin
        n_checks++; if (out_valid_a[i] !== 1'b0) $display("FAIL abort out_valid lat%0d c%0d got %b exp 0", lat_a[i], c, out_valid_a[i]); else n_pass++;
      end
      tick();
    end
    run_word(32'h01020304, "after_abort");
  endtask

  // Inputs held valid and ready: instance i accepts every 6+L cycles starting at 0.
  task automatic test_back_to_back();
    logic [31:0] words [64];
    out_ready = 1'b1; in_valid = 1'b1;
    for (int n = 0; n < 64; n++) begin
      in_word = $urandom();
      words[n] = in_word;
      for (int i = 0; i < NI; i++) begin
        int L, ph;
        logic exp_v, exp_rdy;
        L = lat_a[i];
        ph = n % (6 + L);
        exp_rdy = (ph == 0);
        exp_v = (ph == 5 + L);
        n_checks++; if (in_ready_a[i] !== exp_rdy) $display("FAIL b2b in_ready lat%0d n%0d got %b exp %b", L, n, in_ready_a[i], exp_rdy); else n_pass++;
        n_checks++; if (out_valid_a[i] !== exp_v) $display("FAIL b2b out_valid lat%0d n%0d got %b exp %b", L, n, out_valid_a[i], exp_v); else n_pass++;
        if (exp_v) begin
          n_checks++; if (out_word_a[i] !== subword(words[n-5-L])) $display("FAIL b2b out_word lat%0d n%0d got %h exp %h", L, n, out_word_a[i], subword(words[n-5-L])); else n_pass++;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 10; n++) tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_residue();
    test_random_words();
    test_hold_output();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
